mp_grf: RTL and testbench
=========================

MP_GRF -- requirements
Module: mp_grf

Interface
REQ-001 The block SHALL expose parameter DATA_W, default 32, register data width in bits.
REQ-002 The block SHALL expose parameter ADDR_W, default 5, register address width; register count = 2^ADDR_W.
REQ-003 The block SHALL expose parameter BYPASS, default 1, enabling same-cycle write-to-read forwarding when 1.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset: clk  input  1  rising-edge clock.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 rd_a1, rd_a2  input  ADDR_W each  read addresses.
REQ-007 rd_d1, rd_d2  output  DATA_W each  read data.
REQ-008 rd_busy1, rd_busy2  output  1 each  register has an outstanding producer.
REQ-009 wa_en  input  1; wa_addr  input  ADDR_W; wa_data  input  DATA_W: write port A (older).
REQ-010 wb_en  input  1; wb_addr  input  ADDR_W; wb_data  input  DATA_W: write port B (younger).
REQ-011 iss_en  input  1; iss_addr  input  ADDR_W: marks a register pending (new producer issued).

Function
REQ-012 Register 0 SHALL always read 0, never be written, never be pending; writes/issues to address 0 are ignored.
REQ-013 Reads SHALL be combinational, zero-latency; writes SHALL commit on rising clk edge.
REQ-014 Port A and port B enabled to the same nonzero address in one cycle: port B data SHALL be stored.
REQ-015 Pending bit for address X SHALL be set at the edge when iss_en=1 and iss_addr=X.
REQ-016 Pending bit for X SHALL clear at the edge when either write port writes X and no issue to X occurs that cycle.
REQ-017 Issue and write to the same address in one cycle: data SHALL be stored and pending SHALL end 1.
REQ-018 BYPASS=1: read address X nonzero matching an enabled write port SHALL return that port's write data, port B over port A.
REQ-019 BYPASS=1: rd_busyN SHALL be 0 when its address matches an enabled write port, else the stored pending bit.
REQ-020 BYPASS=0: rd_dN and rd_busyN SHALL reflect only stored state; new values visible the cycle after the edge.
REQ-021 Issue in the current cycle SHALL NOT affect rd_busyN until after the edge.
REQ-022 All address/data arithmetic SHALL be width-exact; no truncation or sign extension of DATA_W data.

Reset
REQ-023 At a rising edge with reset=1 all registers SHALL become 0 and all pending bits 0.
REQ-024 During a reset cycle writes and issues SHALL be ignored; reads SHALL still follow REQ-018..020 combinationally.
REQ-025 After reset deasserts, the first edge SHALL accept writes and issues normally.

Verification
REQ-026 Reset, then read all addresses -> rd_d=0, rd_busy=0 everywhere.
REQ-027 wa_en=1 addr 5 data 0x1234_5678, same cycle rd_a1=5 -> rd_d1=0x1234_5678 (BYPASS=1); next cycle stored value 0x1234_5678; BYPASS=0 -> old value 0 that cycle.
REQ-028 wa addr 7 data 0xAAAA_AAAA and wb addr 7 data 0x5555_5555 same cycle -> next cycle reg7=0x5555_5555; same-cycle bypass read 0x5555_5555.
REQ-029 iss addr 3 -> next cycle rd_busy=1 for 3; wb write 3 data 0x42 -> same cycle busy=0 (BYPASS=1), next cycle busy=0, data 0x42.
REQ-030 iss addr 9 and wa write 9 data 0x99 same cycle -> next cycle reg9=0x99, busy=1; writes/issues to addr 0 -> reads 0, busy 0.
REQ-031 Write reg 4 = 0xDEAD_BEEF, issue 4, then reset with wa write 4 data 0x1 asserted -> reg4=0, busy 0; non-default DATA_W=16, ADDR_W=3 run repeats REQ-027/028.

Source files
------------

// File: rtl/mp_grf_if.sv
// Read/write/issue bundle for the mp_grf register file.
interface mp_grf_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5
);
   logic [ADDR_W-1:0] rd_a1;
   logic [ADDR_W-1:0] rd_a2;
   logic [DATA_W-1:0] rd_d1;
   logic [DATA_W-1:0] rd_d2;
   logic              rd_busy1;
   logic              rd_busy2;
   logic              wa_en;
   logic [ADDR_W-1:0] wa_addr;
   logic [DATA_W-1:0] wa_data;
   logic              wb_en;
   logic [ADDR_W-1:0] wb_addr;
   logic [DATA_W-1:0] wb_data;
   logic              iss_en;
   logic [ADDR_W-1:0] iss_addr;

   modport master (
      output rd_a1, rd_a2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             iss_en, iss_addr,
      input  rd_d1, rd_d2, rd_busy1, rd_busy2
   );

   modport slave (
      input  rd_a1, rd_a2, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
             iss_en, iss_addr,
      output rd_d1, rd_d2, rd_busy1, rd_busy2
   );
endinterface

// File: rtl/mp_grf.sv
// Two-write, two-read register file with per-register pending (scoreboard) bits
// and optional same-cycle write-to-read forwarding; register 0 is hardwired zero.
module mp_grf #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter bit          BYPASS = 1'b1
) (
   input  logic      clk,
   input  logic      reset,
   mp_grf_if.slave   bus
);
   localparam int unsigned NREG = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [NREG];
   logic [DATA_W-1:0] regs_d [NREG];
   logic [NREG-1:0]   pend_q;
   logic [NREG-1:0]   pend_d;
   logic              wa_ok;
   logic              wb_ok;
   logic              iss_ok;

   assign wa_ok  = bus.wa_en  && (bus.wa_addr  != '0);
   assign wb_ok  = bus.wb_en  && (bus.wb_addr  != '0);
   assign iss_ok = bus.iss_en && (bus.iss_addr != '0);

   // Port B is younger so it lands last; an issue outranks a completing write.
   always_comb begin
      regs_d = regs_q;
      pend_d = pend_q;
      if (wa_ok) begin
         regs_d[bus.wa_addr] = bus.wa_data;
         pend_d[bus.wa_addr] = 1'b0;
      end
      if (wb_ok) begin
         regs_d[bus.wb_addr] = bus.wb_data;
         pend_d[bus.wb_addr] = 1'b0;
      end
      if (iss_ok) begin
         pend_d[bus.iss_addr] = 1'b1;
      end
      regs_d[0] = '0;
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         regs_q <= regs_d;
         pend_q <= pend_d;
      end
   end

   // Returns {busy, data}; forwarding ignores reset so reads stay purely combinational.
   function automatic logic [DATA_W:0] rd_port(input logic [ADDR_W-1:0] a);
      logic [DATA_W:0] r;
      r = {pend_q[a], regs_q[a]};
      if (BYPASS) begin
         if (wb_ok && (bus.wb_addr == a)) begin
            r = {1'b0, bus.wb_data};
         end else if (wa_ok && (bus.wa_addr == a)) begin
            r = {1'b0, bus.wa_data};
         end
      end
      return r;
   endfunction

   assign {bus.rd_busy1, bus.rd_d1} = rd_port(bus.rd_a1);
   assign {bus.rd_busy2, bus.rd_d2} = rd_port(bus.rd_a2);
endmodule

// File: tb/tb_mp_grf.sv
// Bench for mp_grf: three instances (forwarding, no forwarding, narrow 16x8) share
// one stimulus stream and are compared against an array-based register model.
module tb_mp_grf;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        s_reset;
   logic [4:0]  s_ra1, s_ra2, s_wa_addr, s_wb_addr, s_iss_addr;
   logic [31:0] s_wa_data, s_wb_data;
   logic        s_wa_en, s_wb_en, s_iss_en;

   int n_checks = 0;
   int n_fail   = 0;

   mp_grf_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
   mp_grf_if #(.DATA_W(32), .ADDR_W(5)) if1 ();
   mp_grf_if #(.DATA_W(16), .ADDR_W(3)) if2 ();

   assign if0.rd_a1 = s_ra1;        assign if1.rd_a1 = s_ra1;        assign if2.rd_a1 = s_ra1[2:0];
   assign if0.rd_a2 = s_ra2;        assign if1.rd_a2 = s_ra2;        assign if2.rd_a2 = s_ra2[2:0];
   assign if0.wa_en = s_wa_en;      assign if1.wa_en = s_wa_en;      assign if2.wa_en = s_wa_en;
   assign if0.wa_addr = s_wa_addr;  assign if1.wa_addr = s_wa_addr;  assign if2.wa_addr = s_wa_addr[2:0];
   assign if0.wa_data = s_wa_data;  assign if1.wa_data = s_wa_data;  assign if2.wa_data = s_wa_data[15:0];
   assign if0.wb_en = s_wb_en;      assign if1.wb_en = s_wb_en;      assign if2.wb_en = s_wb_en;
   assign if0.wb_addr = s_wb_addr;  assign if1.wb_addr = s_wb_addr;  assign if2.wb_addr = s_wb_addr[2:0];
   assign if0.wb_data = s_wb_data;  assign if1.wb_data = s_wb_data;  assign if2.wb_data = s_wb_data[15:0];
   assign if0.iss_en = s_iss_en;    assign if1.iss_en = s_iss_en;    assign if2.iss_en = s_iss_en;
   assign if0.iss_addr = s_iss_addr; assign if1.iss_addr = s_iss_addr; assign if2.iss_addr = s_iss_addr[2:0];

   mp_grf #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b1)) u0 (.clk(clk), .reset(s_reset), .bus(if0));
   mp_grf #(.DATA_W(32), .ADDR_W(5), .BYPASS(1'b0)) u1 (.clk(clk), .reset(s_reset), .bus(if1));
   mp_grf #(.DATA_W(16), .ADDR_W(3), .BYPASS(1'b1)) u2 (.clk(clk), .reset(s_reset), .bus(if2));

   logic [31:0] od1 [3];
   logic [31:0] od2 [3];
   logic        ob1 [3];
   logic        ob2 [3];
   assign od1[0] = if0.rd_d1;  assign od1[1] = if1.rd_d1;  assign od1[2] = 32'(if2.rd_d1);
   assign od2[0] = if0.rd_d2;  assign od2[1] = if1.rd_d2;  assign od2[2] = 32'(if2.rd_d2);
   assign ob1[0] = if0.rd_busy1; assign ob1[1] = if1.rd_busy1; assign ob1[2] = if2.rd_busy1;
   assign ob2[0] = if0.rd_busy2; assign ob2[1] = if1.rd_busy2; assign ob2[2] = if2.rd_busy2;

   // Reference state per instance; the narrow instance uses only the low 8 entries.
   logic [31:0] m_reg  [3][32];
   bit          m_pend [3][32];

   function automatic int amask(input int k);
      return (k == 2) ? 7 : 31;
   endfunction

   function automatic logic [31:0] dmask(input int k);
      return (k == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
   endfunction

   // Expected {busy, data} for instance k reading address ra under current inputs.
   function automatic logic [32:0] expect_rd(input int k, input logic [4:0] ra);
      int a, wa, wb;
      a  = int'(ra)        & amask(k);
      wa = int'(s_wa_addr) & amask(k);
      wb = int'(s_wb_addr) & amask(k);
      if (a == 0) return 33'd0;
      if (k != 1) begin
         if (s_wb_en && wb == a) return {1'b0, s_wb_data & dmask(k)};
         if (s_wa_en && wa == a) return {1'b0, s_wa_data & dmask(k)};
      end
      return {m_pend[k][a], m_reg[k][a]};
   endfunction

   function automatic void commit();
      int wa, wb, ia;
      for (int k = 0; k < 3; k++) begin
         if (s_reset) begin
            for (int a = 0; a < 32; a++) begin
               m_reg[k][a]  = 32'd0;
               m_pend[k][a] = 1'b0;
            end
         end else begin
            wa = int'(s_wa_addr)  & amask(k);
            wb = int'(s_wb_addr)  & amask(k);
            ia = int'(s_iss_addr) & amask(k);
            if (s_wa_en && wa != 0) begin m_reg[k][wa] = s_wa_data & dmask(k); m_pend[k][wa] = 1'b0; end
            if (s_wb_en && wb != 0) begin m_reg[k][wb] = s_wb_data & dmask(k); m_pend[k][wb] = 1'b0; end
            if (s_iss_en && ia != 0) m_pend[k][ia] = 1'b1;
         end
      end
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [32:0] e1, e2;
      for (int k = 0; k < 3; k++) begin
         e1 = expect_rd(k, s_ra1);
         e2 = expect_rd(k, s_ra2);
         check($sformatf("rd_d1_u%0d", k), od1[k], e1[31:0]);
         check($sformatf("rd_d2_u%0d", k), od2[k], e2[31:0]);
         check($sformatf("busy1_u%0d", k), 32'(ob1[k]), 32'(e1[32]));
         check($sformatf("busy2_u%0d", k), 32'(ob2[k]), 32'(e2[32]));
      end
   endtask

   task automatic cyc_begin();
      @(negedge clk);
      s_reset = 1'b0;
      s_wa_en = 1'b0; s_wb_en = 1'b0; s_iss_en = 1'b0;
      s_ra1 = 5'd0; s_ra2 = 5'd0; s_wa_addr = 5'd0; s_wb_addr = 5'd0; s_iss_addr = 5'd0;
      s_wa_data = 32'd0; s_wb_data = 32'd0;
   endtask

   task automatic settle();
      #1;
      compare_all();
   endtask

   task automatic tick();
      @(posedge clk);
      commit();
   endtask

   initial begin
      cyc_begin();
      s_reset = 1'b1;
      tick();

      // All addresses read zero and idle after reset.
      for (int a = 0; a < 32; a++) begin
         cyc_begin();
         s_ra1 = 5'(a); s_ra2 = 5'(31 - a);
         settle();
         check("rst_d1", if0.rd_d1, 32'd0);
         check("rst_busy1", 32'(if0.rd_busy1), 32'd0);
         tick();
      end

      // Single write with same-cycle read of the written address.
      cyc_begin();
      s_wa_en = 1'b1; s_wa_addr = 5'd5; s_wa_data = 32'h1234_5678; s_ra1 = 5'd5;
      settle();
      check("wr5_fwd", if0.rd_d1, 32'h1234_5678);
      check("wr5_nofwd", if1.rd_d1, 32'd0);
      check("wr5_fwd_narrow", 32'(if2.rd_d1), 32'h0000_5678);
      tick();
      cyc_begin();
      s_ra1 = 5'd5;
      settle();
      check("wr5_stored", if0.rd_d1, 32'h1234_5678);
      check("wr5_stored_nofwd", if1.rd_d1, 32'h1234_5678);
      tick();

      // Both ports to one address: the younger port wins.
      cyc_begin();
      s_wa_en = 1'b1; s_wa_addr = 5'd7; s_wa_data = 32'hAAAA_AAAA;
      s_wb_en = 1'b1; s_wb_addr = 5'd7; s_wb_data = 32'h5555_5555;
      s_ra1 = 5'd7; s_ra2 = 5'd7;
      settle();
      check("ab7_fwd", if0.rd_d2, 32'h5555_5555);
      check("ab7_fwd_narrow", 32'(if2.rd_d1), 32'h0000_5555);
      tick();
      cyc_begin();
      s_ra1 = 5'd7;
      settle();
      check("ab7_stored", if0.rd_d1, 32'h5555_5555);
      check("ab7_stored_nofwd", if1.rd_d1, 32'h5555_5555);
      check("ab7_stored_narrow", 32'(if2.rd_d1), 32'h0000_5555);
      tick();

      // Issue then completing write on port B.
      cyc_begin();
      s_iss_en = 1'b1; s_iss_addr = 5'd3; s_ra1 = 5'd3;
      settle();
      check("iss3_same", 32'(if0.rd_busy1), 32'd0);
      tick();
      cyc_begin();
      s_ra1 = 5'd3;
      settle();
      check("iss3_busy", 32'(if0.rd_busy1), 32'd1);
      tick();
      cyc_begin();
      s_wb_en = 1'b1; s_wb_addr = 5'd3; s_wb_data = 32'h42; s_ra1 = 5'd3;
      settle();
      check("wb3_fwd_busy", 32'(if0.rd_busy1), 32'd0);
      check("wb3_nofwd_busy", 32'(if1.rd_busy1), 32'd1);
      tick();
      cyc_begin();
      s_ra1 = 5'd3;
      settle();
      check("wb3_busy", 32'(if0.rd_busy1), 32'd0);
      check("wb3_data", if0.rd_d1, 32'h42);
      tick();

      // Issue and write to the same register: data stored, still pending.
      cyc_begin();
      s_iss_en = 1'b1; s_iss_addr = 5'd9; s_wa_en = 1'b1; s_wa_addr = 5'd9; s_wa_data = 32'h99;
      settle();
      tick();
      cyc_begin();
      s_ra1 = 5'd9;
      settle();
      check("iw9_data", if0.rd_d1, 32'h99);
      check("iw9_busy", 32'(if0.rd_busy1), 32'd1);
      tick();

      // Address 0 ignores writes and issues.
      cyc_begin();
      s_wa_en = 1'b1; s_wa_addr = 5'd0; s_wa_data = 32'hFFFF_FFFF;
      s_wb_en = 1'b1; s_wb_addr = 5'd0; s_wb_data = 32'h1;
      s_iss_en = 1'b1; s_iss_addr = 5'd0;
      settle();
      check("z0_fwd", if0.rd_d1, 32'd0);
      tick();
      cyc_begin();
      settle();
      check("z0_data", if0.rd_d1, 32'd0);
      check("z0_busy", 32'(if0.rd_busy1), 32'd0);
      tick();

      // Reset overrides a concurrent write and clears pending.
      cyc_begin();
      s_wa_en = 1'b1; s_wa_addr = 5'd4; s_wa_data = 32'hDEAD_BEEF;
      settle();
      tick();
      cyc_begin();
      s_iss_en = 1'b1; s_iss_addr = 5'd4;
      settle();
      tick();
      cyc_begin();
      s_reset = 1'b1; s_wa_en = 1'b1; s_wa_addr = 5'd4; s_wa_data = 32'h1; s_ra1 = 5'd4;
      settle();
      tick();
      cyc_begin();
      s_ra1 = 5'd4;
      settle();
      check("rst4_data", if0.rd_d1, 32'd0);
      check("rst4_busy", 32'(if0.rd_busy1), 32'd0);
      tick();

      // Randomized traffic with address bias toward collisions.
      for (int n = 0; n < 600; n++) begin
         cyc_begin();
         s_reset    = ($urandom_range(0, 59) == 0);
         s_wa_en    = 1'($urandom);
         s_wb_en    = 1'($urandom);
         s_iss_en   = 1'($urandom);
         s_wa_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 9)) : 5'($urandom);
         s_wb_addr  = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 9)) : 5'($urandom);
         s_iss_addr = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 9)) : 5'($urandom);
         s_wa_data  = $urandom;
         s_wb_data  = $urandom;
         case ($urandom_range(0, 3))
            0:       s_ra1 = s_wa_addr;
            1:       s_ra1 = s_wb_addr;
            default: s_ra1 = 5'($urandom_range(0, 9));
         endcase
         s_ra2 = ($urandom_range(0, 1) == 1) ? s_iss_addr : 5'($urandom);
         settle();
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
